// File: rtl/alu.sv
// Registered 32-bit EX-stage ALU: one result and an rs==src flag per clock, one cycle latency.
// Define ALU_HILO_EN to let funct 16/18 (mfhi/mflo) return the multiplier's HI/LO words.
module alu (
  input  logic        clka,
  input  logic        rst,
  input  logic        imm_mode,
  input  logic [31:0] rs,
  input  logic [31:0] src,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [63:0] hilo,
  output logic [31:0] data_out,
  output logic        zero
);

  localparam logic [5:0] F_SLL  = 6'd0;
  localparam logic [5:0] F_SRL  = 6'd2;
  localparam logic [5:0] F_SRA  = 6'd3;
  localparam logic [5:0] F_MFHI = 6'd16;
  localparam logic [5:0] F_MFLO = 6'd18;
  localparam logic [5:0] F_ADD  = 6'd32;
  localparam logic [5:0] F_ADDU = 6'd33;
  localparam logic [5:0] F_SUB  = 6'd34;
  localparam logic [5:0] F_SUBU = 6'd35;
  localparam logic [5:0] F_AND  = 6'd36;
  localparam logic [5:0] F_OR   = 6'd37;
  localparam logic [5:0] F_XOR  = 6'd38;
  localparam logic [5:0] F_NOR  = 6'd39;
  localparam logic [5:0] F_SLT  = 6'd42;
  localparam logic [5:0] F_SLTU = 6'd43;

  logic signed [31:0] rs_s;
  logic signed [31:0] src_s;
  logic        [31:0] data_d;
  logic        [31:0] data_q;
  logic               zero_d;
  logic               zero_q;

  assign rs_s  = rs;
  assign src_s = src;

`ifdef ALU_HILO_EN
  logic [31:0] hi_w;
  logic [31:0] lo_w;
  assign hi_w = hilo[63:32];
  assign lo_w = hilo[31:0];
`else
  logic unused_hilo;
  assign unused_hilo = ^hilo;
`endif

  always_comb begin
    data_d = '0;
    zero_d = (rs == src);
    if (imm_mode) begin
      data_d = rs + src;
    end else begin
      case (funct)
        F_ADD, F_ADDU: data_d = rs + src;
        F_SUB, F_SUBU: data_d = rs - src;
        F_AND:         data_d = rs & src;
        F_OR:          data_d = rs | src;
        F_XOR:         data_d = rs ^ src;
        F_NOR:         data_d = ~(rs | src);
        F_SLT:         data_d = {31'b0, (rs_s < src_s)};
        F_SLTU:        data_d = {31'b0, (rs < src)};
        F_SLL:         data_d = src << shamt;
        F_SRL:         data_d = src >> shamt;
        F_SRA:         data_d = src_s >>> shamt;
`ifdef ALU_HILO_EN
        F_MFHI:        data_d = hi_w;
        F_MFLO:        data_d = lo_w;
`endif
        default:       data_d = '0;
      endcase
    end
  end

  // Output register stage: reset clears both result and flag, discarding any in-flight op.
  always_ff @(posedge clka) begin
    if (rst) begin
      data_q <= '0;
      zero_q <= 1'b0;
    end else begin
      data_q <= data_d;
      zero_q <= zero_d;
    end
  end

  assign data_out = data_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: the driver queues hand-computed results, a monitor checks them one cycle later.
module tb_alu;

  logic        clka;
  logic        rst;
  logic        imm_mode;
  logic [31:0] rs;
  logic [31:0] src;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [63:0] hilo;
  logic [31:0] data_out;
  logic        zero;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        zf;
  } exp_t;

  exp_t exp_q[$];
  logic issued;
  logic drv_done;
  int   n_checks;
  int   n_fail;

  alu dut (
    .clka     (clka),
    .rst      (rst),
    .imm_mode (imm_mode),
    .rs       (rs),
    .src      (src),
    .funct    (funct),
    .shamt    (shamt),
    .hilo     (hilo),
    .data_out (data_out),
    .zero     (zero)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

`ifdef ALU_HILO_EN
  localparam logic [31:0] EXP_HI = 32'h0000_0001;
  localparam logic [31:0] EXP_LO = 32'h0000_0002;
`else
  localparam logic [31:0] EXP_HI = 32'h0000_0000;
  localparam logic [31:0] EXP_LO = 32'h0000_0000;
`endif

  task automatic issue(input string nm, input logic r, input logic im,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] f, input logic [4:0] sh,
                       input logic [63:0] hl,
                       input logic [31:0] ed, input logic ez);
    exp_t e;
    @(negedge clka);
    rst      = r;
    imm_mode = im;
    rs       = a;
    src      = b;
    funct    = f;
    shamt    = sh;
    hilo     = hl;
    issued   = 1'b1;
    e.name = nm;
    e.data = ed;
    e.zf   = ez;
    exp_q.push_back(e);
  endtask

  // Monitor: the result of inputs sampled at an edge is visible just after that edge.
  initial begin
    logic pend;
    exp_t e;
    forever begin
      @(posedge clka);
      pend = issued;
      #1;
      if (pend) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s: output with empty scoreboard, got data=%h", "sb_underflow", data_out);
        end else begin
          e = exp_q.pop_front();
          n_checks++;
          if (data_out !== e.data) begin
            n_fail++;
            $display("FAIL %s data_out: got %h expected %h", e.name, data_out, e.data);
          end
          n_checks++;
          if (zero !== e.zf) begin
            n_fail++;
            $display("FAIL %s zero: got %b expected %b", e.name, zero, e.zf);
          end
        end
      end
    end
  end

  initial begin
    issued   = 1'b0;
    drv_done = 1'b0;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    imm_mode = 1'b0;
    rs       = '0;
    src      = '0;
    funct    = '0;
    shamt    = '0;
    hilo     = '0;
    repeat (3) @(posedge clka);

    //     name         rst  imm  rs            src           funct  sh   hilo                    exp data      zero
    issue("reset",      1'b1,1'b0,32'd5,        32'd5,        6'd32, 5'd0, 64'h0,                 32'h0,        1'b0);
    issue("rel_add",    1'b0,1'b0,32'd5,        32'd5,        6'd32, 5'd0, 64'h0,                 32'd10,       1'b1);
    issue("add_wrap",   1'b0,1'b0,32'hFFFFFFFF, 32'd1,        6'd32, 5'd0, 64'h0,                 32'h0,        1'b0);
    issue("sub_wrap",   1'b0,1'b0,32'd3,        32'd5,        6'd34, 5'd0, 64'h0,                 32'hFFFFFFFE, 1'b0);
    issue("slt_neg",    1'b0,1'b0,32'hFFFFFFFF, 32'd1,        6'd42, 5'd0, 64'h0,                 32'd1,        1'b0);
    issue("sltu",       1'b0,1'b0,32'hFFFFFFFF, 32'd1,        6'd43, 5'd0, 64'h0,                 32'd0,        1'b0);
    issue("srl",        1'b0,1'b0,32'h0,        32'h80000000, 6'd2,  5'd2, 64'h0,                 32'h20000000, 1'b0);
    issue("sra",        1'b0,1'b0,32'h0,        32'h80000000, 6'd3,  5'd2, 64'h0,                 32'hE0000000, 1'b0);
    issue("imm_add",    1'b0,1'b1,32'h100,      32'hFFFFFFF0, 6'd42, 5'd0, 64'h0,                 32'hF0,       1'b0);
    issue("beq_eq",     1'b0,1'b1,32'd7,        32'd7,        6'd0,  5'd3, 64'h0,                 32'd14,       1'b1);
    issue("and",        1'b0,1'b0,32'hF0F0,     32'hFF00,     6'd36, 5'd0, 64'h0,                 32'hF000,     1'b0);
    issue("or",         1'b0,1'b0,32'hF0F0,     32'hFF00,     6'd37, 5'd0, 64'h0,                 32'hFFF0,     1'b0);
    issue("xor",        1'b0,1'b0,32'hF0F0,     32'hFF00,     6'd38, 5'd0, 64'h0,                 32'h0FF0,     1'b0);
    issue("nor",        1'b0,1'b0,32'h0,        32'h0,        6'd39, 5'd0, 64'h0,                 32'hFFFFFFFF, 1'b1);
    issue("sll31",      1'b0,1'b0,32'h0,        32'h1,        6'd0,  5'd31,64'h0,                 32'h80000000, 1'b0);
    issue("sll0",       1'b0,1'b0,32'h0,        32'h12345678, 6'd0,  5'd0, 64'h0,                 32'h12345678, 1'b0);
    issue("sra31",      1'b0,1'b0,32'h0,        32'h80000000, 6'd3,  5'd31,64'h0,                 32'hFFFFFFFF, 1'b0);
    issue("mult_zero",  1'b0,1'b0,32'd3,        32'd4,        6'd24, 5'd0, 64'h0,                 32'h0,        1'b0);
    issue("mfhi",       1'b0,1'b0,32'h0,        32'h0,        6'd16, 5'd0, 64'h00000001_00000002, EXP_HI,       1'b1);
    issue("mflo",       1'b0,1'b0,32'h0,        32'h0,        6'd18, 5'd0, 64'h00000001_00000002, EXP_LO,       1'b1);
    issue("funct17",    1'b0,1'b0,32'h9,        32'h9,        6'd17, 5'd0, 64'h00000001_00000002, 32'h0,        1'b1);
    issue("rst_mid",    1'b1,1'b0,32'd1,        32'd1,        6'd32, 5'd0, 64'h0,                 32'h0,        1'b0);
    issue("subu",       1'b0,1'b0,32'd10,       32'd4,        6'd35, 5'd0, 64'h0,                 32'd6,        1'b0);

    @(negedge clka);
    issued = 1'b0;
    drv_done = 1'b1;
  end

  initial begin
    wait (drv_done === 1'b1);
    repeat (3) @(posedge clka);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, pending=%0d expected 0", exp_q.size());
    $fatal(1, "timeout");
  end

endmodule
